// File: rtl/gmii_arb_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
package gmii_arb_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, TAG, DATA, DRAIN, IFG} arb_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 8;
endpackage

// File: rtl/gmii_nport_tx_arbiter_rr_arbiter.sv
// Round-robin picker: first request at or after i_ptr; purely combinational, 0 latency.
// No backpressure of its own; the caller decides when the grant is consumed.
module rr_arbiter #(
    parameter int PORT_NUM = 4,
    parameter int IDX_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic [PORT_NUM-1:0] iv_req,
    input  logic [IDX_W-1:0]    iv_ptr,
    output logic [PORT_NUM-1:0] ov_grant,
    output logic [IDX_W-1:0]    ov_idx,
    output logic                o_any
);
    logic [PORT_NUM-1:0] w_rot;

    // Rotate so that bit 0 is the port the search starts from.
    assign w_rot = PORT_NUM'({iv_req, iv_req} >> iv_ptr);

    always_comb begin
        ov_idx = '0;
        o_any  = 1'b0;
        for (int j = PORT_NUM - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                ov_idx = IDX_W'((int'(iv_ptr) + j) % PORT_NUM);
                o_any  = 1'b1;
            end
        end
        ov_grant = o_any ? (PORT_NUM'(1) << ov_idx) : '0;
    end
endmodule

// File: rtl/gmii_nport_tx_arbiter.sv
// N-port to GMII TX merger: preamble/SFD insertion, IFG, abort on underrun/over-length; data 1 cycle.
// Ready only to the granted port in DATA/DRAIN. Optional GMII_ARB_PORT_TAG_EN adds a port-tag byte.
module gmii_nport_tx_arbiter
    import gmii_arb_pkg::*;
#(
    parameter int PORT_NUM        = 4,
    parameter int IFG_BYTES       = 12,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [PORT_NUM-1:0]            iv_port_valid,
    input  logic [PORT_NUM*8-1:0]          iv_port_data,
    input  logic [PORT_NUM-1:0]            iv_port_last,
    output logic [PORT_NUM-1:0]            ov_port_ready,
    output logic [7:0]                     ov_gmii_txd,
    output logic                           o_gmii_tx_en,
    output logic                           o_gmii_tx_er,
    output logic [$clog2(PORT_NUM)-1:0]    ov_cur_port,
    output logic                           o_frame_done,
    output logic                           o_abort_pulse,
    output logic [CNT_WIDTH-1:0]           ov_frame_cnt,
    output logic [CNT_WIDTH-1:0]           ov_abort_cnt
);
    localparam int IDX_W    = $clog2(PORT_NUM);
    localparam int PRE_W    = $clog2(PREAMBLE_LEN);
    localparam int BCNT_W   = $clog2(MAX_FRAME_BYTES + 1);
    localparam int GAP_W    = $clog2(IFG_BYTES + 2);
    // Two zero cycles are implicit: the IDLE grant cycle and the PREAMBLE output register.
    localparam int GAP_EXIT = (IFG_BYTES > 2) ? IFG_BYTES - 2 : 0;

    arb_state_t          r_state, w_state_nxt;
    logic [PRE_W-1:0]    r_pre_cnt, w_pre_cnt_nxt;
    logic [BCNT_W-1:0]   r_byte_cnt, w_byte_cnt_nxt;
    logic [GAP_W-1:0]    r_gap, w_gap_nxt;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt, r_cur, w_cur_nxt;
    logic [PORT_NUM-1:0] r_grant, w_grant_nxt;
    logic [7:0]          r_txd, w_txd;
    logic                r_en, w_en, r_er, w_er, r_done, w_done, r_abort, w_abort;
    logic [CNT_WIDTH-1:0] r_frame_cnt, r_abort_cnt;

    logic [PORT_NUM-1:0] w_grant;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_any, w_sel_valid, w_sel_last;
    logic [7:0]          w_sel_data;

    rr_arbiter #(.PORT_NUM(PORT_NUM), .IDX_W(IDX_W)) u_rr (
        .iv_req   (iv_port_valid),
        .iv_ptr   (r_ptr),
        .ov_grant (w_grant),
        .ov_idx   (w_gnt_idx),
        .o_any    (w_any)
    );

    assign w_sel_valid   = |(iv_port_valid & r_grant);
    assign w_sel_last    = |(iv_port_last & r_grant);
    assign w_sel_data    = 8'(iv_port_data >> {r_cur, 3'b000});
    assign ov_port_ready = (r_state == DATA || r_state == DRAIN) ? r_grant : '0;

    always_comb begin
        w_state_nxt    = r_state;
        w_pre_cnt_nxt  = r_pre_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_gap_nxt      = r_gap;
        w_ptr_nxt      = r_ptr;
        w_cur_nxt      = r_cur;
        w_grant_nxt    = r_grant;
        w_txd          = 8'h00;
        w_en           = 1'b0;
        w_er           = 1'b0;
        w_done         = 1'b0;
        w_abort        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt   = w_grant;
                    w_cur_nxt     = w_gnt_idx;
                    w_ptr_nxt     = (w_gnt_idx == IDX_W'(PORT_NUM - 1)) ? '0 : w_gnt_idx + 1'b1;
                    w_pre_cnt_nxt = '0;
                    w_state_nxt   = PREAMBLE;
                end
            end
            PREAMBLE: begin
                w_en           = 1'b1;
                w_byte_cnt_nxt = '0;
                w_pre_cnt_nxt  = r_pre_cnt + 1'b1;
                if (r_pre_cnt == PRE_W'(PREAMBLE_LEN - 1)) begin
                    w_txd = SFD_BYTE;
`ifdef GMII_ARB_PORT_TAG_EN
                    w_state_nxt = TAG;
`else
                    w_state_nxt = DATA;
`endif
                end else begin
                    w_txd = PREAMBLE_BYTE;
                end
            end
            TAG: begin
                w_en        = 1'b1;
                w_txd       = 8'(r_cur);
                w_state_nxt = DATA;
            end
            DATA: begin
                w_en = 1'b1;
                if (!w_sel_valid) begin
                    w_er        = 1'b1;
                    w_abort     = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = DRAIN;
                end else if (r_byte_cnt == BCNT_W'(MAX_FRAME_BYTES)) begin
                    w_txd       = w_sel_data;
                    w_er        = 1'b1;
                    w_abort     = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = w_sel_last ? IFG : DRAIN;
                end else begin
                    w_txd          = w_sel_data;
                    w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    if (w_sel_last) begin
                        w_done      = 1'b1;
                        w_gap_nxt   = '0;
                        w_state_nxt = IFG;
                    end
                end
            end
            DRAIN: begin
                if (r_gap < GAP_W'(GAP_EXIT)) w_gap_nxt = r_gap + 1'b1;
                if (w_sel_valid && w_sel_last) w_state_nxt = IFG;
            end
            IFG: begin
                if (r_gap >= GAP_W'(GAP_EXIT)) w_state_nxt = IDLE;
                else                           w_gap_nxt   = r_gap + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_pre_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_gap       <= '0;
            r_ptr       <= '0;
            r_cur       <= '0;
            r_grant     <= '0;
            r_txd       <= '0;
            r_en        <= 1'b0;
            r_er        <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_frame_cnt <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_gap      <= w_gap_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cur      <= w_cur_nxt;
            r_grant    <= w_grant_nxt;
            r_txd      <= w_txd;
            r_en       <= w_en;
            r_er       <= w_er;
            r_done     <= w_done;
            r_abort    <= w_abort;
            if (w_done)  r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_abort) r_abort_cnt <= r_abort_cnt + 1'b1;
        end
    end

    assign ov_gmii_txd   = r_txd;
    assign o_gmii_tx_en  = r_en;
    assign o_gmii_tx_er  = r_er;
    assign ov_cur_port   = r_cur;
    assign o_frame_done  = r_done;
    assign o_abort_pulse = r_abort;
    assign ov_frame_cnt  = r_frame_cnt;
    assign ov_abort_cnt  = r_abort_cnt;
endmodule
